// File: rtl/data_mem_responder_if.sv
// CPU data-memory bus between the core (master) and the memory-side responder (slave).
// Carries the word address, write data, write strobe and combinational read data.
interface data_mem_responder_if;
  logic [15:0] mem_access_addr;
  logic [15:0] mem_write_data;
  logic        mem_write_en;
  logic [15:0] mem_read_data;

  modport master (
    output mem_access_addr,
    output mem_write_data,
    output mem_write_en,
    input  mem_read_data
  );

  modport slave (
    input  mem_access_addr,
    input  mem_write_data,
    input  mem_write_en,
    output mem_read_data
  );
endinterface

// File: rtl/data_mem_responder.sv
// Memory-side responder: 16-bit word RAM with a post-reset self-clear,
// sticky write-error flags and a saturating committed-write counter.
module data_mem_responder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  output logic                 init_busy,
  output logic                 addr_err,
  output logic                 drop_err,
  output logic [15:0]          write_count
);
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, READY} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  clear_ptr;
  logic [ADDR_W-1:0]  index;
  logic               in_range;
  logic [15:0]        mem [DEPTH];

  logic               mem_we;
  logic [ADDR_W-1:0]  mem_wa;
  logic [15:0]        mem_wd;

  always_comb begin
    index    = bus.mem_access_addr[ADDR_W-1:0];
    in_range = (bus.mem_access_addr >> ADDR_W) == 16'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clear_ptr   <= '0;
      addr_err    <= 1'b0;
      drop_err    <= 1'b0;
      write_count <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clear_ptr <= clear_ptr + 1'b1;
          if (clear_ptr == '1)
            state <= READY;
          if (bus.mem_write_en)
            drop_err <= 1'b1;
        end
        READY: begin
          if (bus.mem_write_en) begin
            if (in_range) begin
              if (write_count != '1)
                write_count <= write_count + 16'd1;
            end else begin
              addr_err <= 1'b1;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Single write port shared by the self-clear and CPU writes; the reset
  // edge itself leaves the array untouched.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = index;
    mem_wd = bus.mem_write_data;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
        mem_wa = clear_ptr;
        mem_wd = '0;
      end else if (bus.mem_write_en && in_range) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we)
      mem[mem_wa] <= mem_wd;
  end

  always_comb begin
    init_busy         = (state == CLEAR);
    bus.mem_read_data = (state == READY && in_range) ? mem[index] : '0;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a behavioural
// memory model, plus directed scenarios with literal expectations.
module tb_data_mem_responder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        init_busy;
  logic        addr_err;
  logic        drop_err;
  logic [15:0] write_count;

  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(.ADDR_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .init_busy   (init_busy),
    .addr_err    (addr_err),
    .drop_err    (drop_err),
    .write_count (write_count)
  );

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: after reset the array is all zeros and the block is
  // unavailable for 256 edges; then plain RAM semantics with error rules.
  bit          m_valid = 1'b0;
  int          m_left  = 0;
  logic [15:0] m_mem [256];
  bit          m_aerr, m_derr;
  logic [15:0] m_cnt;

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b1;
      m_left  = 256;
      foreach (m_mem[i]) m_mem[i] = 16'h0000;
      m_aerr  = 1'b0;
      m_derr  = 1'b0;
      m_cnt   = 16'h0000;
    end else if (m_valid) begin
      if (m_left > 0) begin
        if (bus.mem_write_en) m_derr = 1'b1;
        m_left--;
      end else if (bus.mem_write_en) begin
        if (bus.mem_access_addr < 16'd256) begin
          m_mem[bus.mem_access_addr[7:0]] = bus.mem_write_data;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
          m_aerr = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] a;
    logic [15:0] exp_rd;
    if (m_valid) begin
      a      = bus.mem_access_addr;
      exp_rd = (m_left > 0 || a > 16'd255) ? 16'h0000 : m_mem[a[7:0]];
      chk("init_busy",   {31'd0, init_busy}, {31'd0, m_left > 0});
      chk("read_data",   {16'd0, bus.mem_read_data}, {16'd0, exp_rd});
      chk("addr_err",    {31'd0, addr_err}, {31'd0, m_aerr});
      chk("drop_err",    {31'd0, drop_err}, {31'd0, m_derr});
      chk("write_count", {16'd0, write_count}, {16'd0, m_cnt});
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic measure_clear(output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    bus.mem_access_addr = a;
    bus.mem_write_data  = d;
    bus.mem_write_en    = 1'b1;
    tick();
    bus.mem_write_en    = 1'b0;
  endtask

  task automatic peek(input logic [15:0] a, output logic [15:0] rd);
    bus.mem_access_addr = a;
    #1;
    rd = bus.mem_read_data;
  endtask

  initial begin
    int          n;
    logic [15:0] rd;

    bus.mem_access_addr = '0;
    bus.mem_write_data  = '0;
    bus.mem_write_en    = 1'b0;

    // Power-up reset and clear latency.
    tick();
    tick();
    rst = 1'b0;
    chk("reset_busy", {31'd0, init_busy}, 32'd1);
    chk("reset_rd",   {16'd0, bus.mem_read_data}, 32'd0);
    measure_clear(n);
    chk("clear_len0", n, 32'd256);

    // Write/read with same-cycle old value.
    bus.mem_access_addr = 16'h0010;
    bus.mem_write_data  = 16'h1234;
    bus.mem_write_en    = 1'b1;
    #1;
    chk("same_cycle_old", {16'd0, bus.mem_read_data}, 32'h0000);
    tick();
    bus.mem_write_en = 1'b0;
    chk("readback", {16'd0, bus.mem_read_data}, 32'h1234);
    chk("count_one", {16'd0, write_count}, 32'd1);

    // Preload then reset: clear must wipe it.
    wr(16'h0005, 16'hBEEF);
    peek(16'h0005, rd);
    chk("preload", {16'd0, rd}, 32'hBEEF);
    do_reset();
    measure_clear(n);
    chk("clear_len1", n, 32'd256);
    peek(16'h0005, rd);
    chk("cleared_5", {16'd0, rd}, 32'h0000);
    chk("count_zero", {16'd0, write_count}, 32'd0);

    // Out of range.
    wr(16'h0100, 16'hAAAA);
    chk("addr_err_set", {31'd0, addr_err}, 32'd1);
    peek(16'h0000, rd);
    chk("oor_alias0", {16'd0, rd}, 32'h0000);
    peek(16'h0100, rd);
    chk("oor_read", {16'd0, rd}, 32'h0000);
    chk("oor_count", {16'd0, write_count}, 32'd0);

    // Write during clear.
    do_reset();
    repeat (9) tick();
    wr(16'h0003, 16'h5555);
    chk("drop_err_set", {31'd0, drop_err}, 32'd1);
    measure_clear(n);
    chk("clear_done", {31'd0, init_busy}, 32'd0);
    peek(16'h0003, rd);
    chk("dropped_3", {16'd0, rd}, 32'h0000);
    chk("drop_count", {16'd0, write_count}, 32'd0);

    // Reset mid-clear restarts the full clear and clears flags.
    do_reset();
    repeat (9) tick();
    wr(16'h0007, 16'h7777);
    repeat (90) tick();
    chk("pre_rst_drop", {31'd0, drop_err}, 32'd1);
    do_reset();
    chk("mid_drop_clr", {31'd0, drop_err}, 32'd0);
    chk("mid_addr_clr", {31'd0, addr_err}, 32'd0);
    measure_clear(n);
    chk("clear_len2", n, 32'd256);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      bus.mem_access_addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      bus.mem_write_data  = 16'($urandom);
      bus.mem_write_en    = ($urandom_range(0, 1) == 1);
      rst                 = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    bus.mem_write_en = 1'b0;

    // Saturation.
    do_reset();
    measure_clear(n);
    for (int i = 0; i < 65540; i++) begin
      bus.mem_access_addr = 16'($urandom_range(0, 255));
      bus.mem_write_data  = 16'($urandom);
      bus.mem_write_en    = 1'b1;
      tick();
    end
    bus.mem_write_en = 1'b0;
    tick();
    chk("sat_count", {16'd0, write_count}, 32'hFFFF);
    chk("sat_aerr",  {31'd0, addr_err}, 32'd0);
    chk("sat_derr",  {31'd0, drop_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
